// File: rtl/svc_acc_window.sv
// Windowed sum controller around svc_accumulator: collects 2**LOG2_N samples (or a flushed
// partial window), waits out the accumulator latency, then captures and clears. Option: SVC_ACC_WINDOW_AVG_EN.
module svc_acc_window #(
    parameter int WIDTH       = 32,
    parameter int LOG2_N      = 4,
    parameter int ACC_LATENCY = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  in_data,
    output logic              in_ready,
    input  logic              flush,
    output logic              acc_en,
    output logic [WIDTH-1:0]  acc_val,
    output logic              acc_clr,
    input  logic [WIDTH-1:0]  acc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_sum,
    output logic [LOG2_N:0]   out_count,
`ifdef SVC_ACC_WINDOW_AVG_EN
    output logic [WIDTH-1:0]  out_avg,
`endif
    output logic              out_partial
);

    localparam int CW  = LOG2_N + 1;
    localparam int N   = 1 << LOG2_N;
    localparam int DCW = (ACC_LATENCY > 1) ? $clog2(ACC_LATENCY) : 1;

    typedef enum logic [1:0] {ST_ACC, ST_DRAIN, ST_CAPTURE} state_t;

    state_t          state, state_next;
    logic [CW-1:0]   count, count_next;
    logic [DCW-1:0]  drain_cnt, drain_next;
    logic            partial, partial_next;
    logic            capture;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_next   = state;
        count_next   = count;
        drain_next   = drain_cnt;
        partial_next = partial;
        in_ready     = 1'b0;
        acc_en       = 1'b0;
        acc_clr      = 1'b0;
        capture      = 1'b0;
        acc_val      = in_data;
        unique case (state)
            ST_ACC: begin
                in_ready = 1'b1;
                acc_en   = in_valid;
                if (in_valid) count_next = count + 1'b1;
                // A full window or a flush of a non-empty window (including this cycle's sample) closes it.
                if ((in_valid && count_next == CW'(N)) || (flush && count_next != '0)) begin
                    state_next   = ST_DRAIN;
                    drain_next   = DCW'(ACC_LATENCY - 1);
                    partial_next = (count_next != CW'(N));
                end
            end
            ST_DRAIN: begin
                if (drain_cnt == '0) state_next = ST_CAPTURE;
                else                 drain_next = drain_cnt - 1'b1;
            end
            ST_CAPTURE: begin
                if (!out_valid || out_ready) begin
                    capture    = 1'b1;
                    acc_clr    = 1'b1;
                    count_next = '0;
                    state_next = ST_ACC;
                end
            end
            default: state_next = ST_ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous (sampled on clk) and all state uses non-blocking assignments.
        if (!rst_n) begin
            state     <= ST_ACC;
            count     <= '0;
            drain_cnt <= '0;
            partial   <= 1'b0;
        end else begin
            state     <= state_next;
            count     <= count_next;
            drain_cnt <= drain_next;
            partial   <= partial_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_sum     <= '0;
            out_count   <= '0;
            out_partial <= 1'b0;
`ifdef SVC_ACC_WINDOW_AVG_EN
            out_avg     <= '0;
`endif
        end else if (capture) begin
            out_valid   <= 1'b1;
            out_sum     <= acc;
            out_count   <= count;
            out_partial <= partial;
`ifdef SVC_ACC_WINDOW_AVG_EN
            out_avg     <= partial ? '0 : (acc >> LOG2_N);
`endif
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_svc_acc_window.sv
// Directed bench for svc_acc_window with a behavioural 6-cycle accumulator model.
// Build with SVC_ACC_WINDOW_AVG_EN defined to also cover out_avg.
module tb_svc_acc_window;

    localparam int WIDTH       = 32;
    localparam int LOG2_N      = 2;
    localparam int ACC_LATENCY = 6;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic [WIDTH-1:0]  in_data = '0;
    logic              in_ready;
    logic              flush = 1'b0;
    logic              acc_en;
    logic [WIDTH-1:0]  acc_val;
    logic              acc_clr;
    logic [WIDTH-1:0]  acc;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [WIDTH-1:0]  out_sum;
    logic [LOG2_N:0]   out_count;
    logic              out_partial;
`ifdef SVC_ACC_WINDOW_AVG_EN
    logic [WIDTH-1:0]  out_avg;
`endif

    int errors = 0;
    int checks = 0;
    int en_cnt = 0;
    int en_bad = 0;
    int overlap = 0;

    always #5 clk = ~clk;

    svc_acc_window #(.WIDTH(WIDTH), .LOG2_N(LOG2_N), .ACC_LATENCY(ACC_LATENCY)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .flush(flush), .acc_en(acc_en), .acc_val(acc_val), .acc_clr(acc_clr), .acc(acc),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_count(out_count),
`ifdef SVC_ACC_WINDOW_AVG_EN
        .out_avg(out_avg),
`endif
        .out_partial(out_partial)
    );

    // Accumulator stand-in: en/val delayed ACC_LATENCY-1 cycles, then added into acc.
    logic [ACC_LATENCY-2:0] pen;
    logic [WIDTH-1:0]       pval [ACC_LATENCY-1];
    always @(posedge clk) begin
        if (!rst_n) begin
            pen <= '0;
            acc <= '0;
        end else begin
            pen     <= {pen[ACC_LATENCY-3:0], acc_en};
            pval[0] <= acc_val;
            for (int i = 1; i < ACC_LATENCY - 1; i++) pval[i] <= pval[i-1];
            if (acc_clr)                 acc <= '0;
            else if (pen[ACC_LATENCY-2]) acc <= acc + pval[ACC_LATENCY-2];
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            if (acc_en)             en_cnt  <= en_cnt + 1;
            if (acc_en && !in_valid) en_bad  <= en_bad + 1;
            if (acc_en && acc_clr)  overlap <= overlap + 1;
        end
    end

    task automatic send(input logic [WIDTH-1:0] v);
        int t;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
        end
        in_valid = 1'b1;
        in_data  = v;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic wait_result(input string name, input logic [WIDTH-1:0] es,
                               input int ec, input logic ep, output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_valid: out_valid=%0b required 1", name, out_valid);
        end
        checks++;
        if (out_sum !== es) begin
            errors++;
            $display("FAIL %s_sum: got %h required %h", name, out_sum, es);
        end
        checks++;
        if (out_count !== (LOG2_N+1)'(ec)) begin
            errors++;
            $display("FAIL %s_count: got %0d required %0d", name, out_count, ec);
        end
        checks++;
        if (out_partial !== ep) begin
            errors++;
            $display("FAIL %s_partial: got %0b required %0b", name, out_partial, ep);
        end
    endtask

    task automatic expect_quiet(input string name, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL %s_quiet: out_valid high %0d cycles required 0", name, seen);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b0)   begin errors++; $display("FAIL rst_valid: got %0b required 0", out_valid); end
        checks++; if (out_sum !== '0)       begin errors++; $display("FAIL rst_sum: got %h required 0", out_sum); end
        checks++; if (out_count !== '0)     begin errors++; $display("FAIL rst_count: got %0d required 0", out_count); end
        checks++; if (out_partial !== 1'b0) begin errors++; $display("FAIL rst_partial: got %0b required 0", out_partial); end
        checks++; if (in_ready !== 1'b1)    begin errors++; $display("FAIL rst_ready: got %0b required 1", in_ready); end
        checks++; if (acc_clr !== 1'b0)     begin errors++; $display("FAIL rst_clr: got %0b required 0", acc_clr); end
        rst_n = 1'b1;
    endtask

    task automatic test_full_window();
        int lat;
        send(1); send(2); send(3); send(4);
        idle();
        wait_result("full", 32'd10, 4, 1'b0, lat);
        checks++;
        if (lat !== 7) begin
            errors++;
            $display("FAIL full_latency: got %0d cycles required 7", lat);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL full_drop: out_valid=%0b required 0", out_valid); end
    endtask

    task automatic test_flush();
        int lat;
        send(5); send(7);
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        wait_result("flush", 32'd12, 2, 1'b1, lat);
        // Flush arriving with a sample: the sample joins the window, then it closes.
        send(6); send(8);
        flush = 1'b1;
        idle();
        wait_result("flush_accept", 32'd14, 2, 1'b1, lat);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        expect_quiet("flush_empty", 20);
    endtask

    task automatic test_back_to_back();
        int lat;
        out_ready = 1'b0;
        send(1); send(2); send(3); send(4);
        idle();
        wait_result("stall_first", 32'd10, 4, 1'b0, lat);
        send(10); send(20); send(30); send(40);
        idle();
        repeat (15) @(negedge clk);
        checks++; if (out_sum !== 32'd10) begin errors++; $display("FAIL stall_hold_sum: got %h required %h", out_sum, 32'd10); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_hold_valid: got %0b required 1", out_valid); end
        checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL stall_ready: got %0b required 0", in_ready); end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %0b required 1", out_valid); end
        checks++; if (out_sum !== 32'd100) begin errors++; $display("FAIL b2b_sum: got %h required %h", out_sum, 32'd100); end
        checks++; if (out_count !== 3'd4)  begin errors++; $display("FAIL b2b_count: got %0d required 4", out_count); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drop: got %0b required 0", out_valid); end
    endtask

    task automatic test_wrap();
        int lat;
        repeat (4) send(32'hFFFF_FFFF);
        idle();
        wait_result("wrap", 32'hFFFF_FFFC, 4, 1'b0, lat);
`ifdef SVC_ACC_WINDOW_AVG_EN
        checks++;
        if (out_avg !== 32'h3FFF_FFFF) begin
            errors++;
            $display("FAIL wrap_avg: got %h required %h", out_avg, 32'h3FFF_FFFF);
        end
`endif
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        int lat;
        send(9); send(9); send(9);
        idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        expect_quiet("mid_reset", 20);
        send(2); send(2); send(2); send(2);
        idle();
        wait_result("after_reset", 32'd8, 4, 1'b0, lat);
        @(negedge clk);
    endtask

    task automatic test_sparse_input();
        int lat;
        int en_start;
        en_start = en_cnt;
        for (int i = 0; i < 4; i++) begin
            send(1);
            idle();
        end
        wait_result("sparse", 32'd4, 4, 1'b0, lat);
        checks++;
        if (en_cnt - en_start !== 4) begin
            errors++;
            $display("FAIL sparse_en_count: got %0d required 4", en_cnt - en_start);
        end
        checks++;
        if (en_bad !== 0) begin errors++; $display("FAIL en_without_valid: got %0d required 0", en_bad); end
        checks++;
        if (overlap !== 0) begin errors++; $display("FAIL clr_en_overlap: got %0d required 0", overlap); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_full_window();
        test_flush();
        test_back_to_back();
        test_wrap();
        test_mid_reset();
        test_sparse_input();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
